prim_subreg_upd_sched: RTL

Hardware-update scheduler for a single register field. It collects update requests from NReq hardware sources, picks one winner per cycle by round-robin, and stages the winner's value in a one-entry buffer. It then drives the de/d hardware-write port of that field's prim_subreg_arb. Because software writes win inside prim_subreg_arb, the scheduler withholds de_o in any cycle where the software write enable is high and retries later, so no hardware update is silently lost.

---
 rtl/prim_subreg_upd_sched.sv | 95 +++++++++
 1 files changed

// File: rtl/prim_subreg_upd_sched.sv
// Hardware-update scheduler for one register field: round-robin pick among
// NReq sources, one-entry staging buffer, and a de/d port that yields to software writes.
module prim_subreg_upd_sched #(
  parameter int NReq     = 4,
  parameter int DW       = 32,
  parameter int MaxStall = 15
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NReq-1:0]                req_i,
  input  logic [NReq-1:0][DW-1:0]        data_i,
  output logic [NReq-1:0]                gnt_o,
  input  logic                           sw_we_i,
  input  logic                           clear_i,
  output logic                           de_o,
  output logic [DW-1:0]                  d_o,
  output logic                           busy_o,
  output logic                           starve_o,
  output logic [$clog2(NReq)-1:0]        dbg_rr_ptr_o,
  output logic [$clog2(MaxStall+1)-1:0]  dbg_stall_cnt_o
);

  localparam int PW  = $clog2(NReq);
  localparam int SCW = $clog2(MaxStall + 1);

  logic            r_stage_vld;
  logic [DW-1:0]   r_stage_data;
  logic [PW-1:0]   r_rr_ptr;
  logic [SCW-1:0]  r_stall_cnt;

  logic            w_issue;
  logic            w_free;
  logic            w_found;
  logic [PW-1:0]   w_win;
  logic [PW-1:0]   w_cand;
  logic [NReq-1:0] w_gnt;

  // Handshake: a source holds req_i with stable data_i until it sees gnt_o;
  // data is captured on the edge that ends the grant cycle. de_o is offered
  // only when software is not writing the field in the same cycle.
  assign w_issue = r_stage_vld & ~sw_we_i;
  assign w_free  = ~r_stage_vld | w_issue;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    w_gnt   = '0;
    if (w_free && !clear_i) begin
      // Scan starting one past the last winner so every source rotates through.
      for (int i = 1; i <= NReq; i++) begin
        w_cand = PW'((int'(r_rr_ptr) + i) % NReq);
        if (!w_found && req_i[w_cand]) begin
          w_found = 1'b1;
          w_win   = w_cand;
        end
      end
    end
    if (w_found) w_gnt[w_win] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stage_vld  <= 1'b0;
      r_stage_data <= '0;
      r_rr_ptr     <= PW'(NReq - 1);
      r_stall_cnt  <= '0;
    end else begin
      if (clear_i) begin
        r_stage_vld <= 1'b0;
      end else if (w_found) begin
        r_stage_vld  <= 1'b1;
        r_stage_data <= data_i[w_win];
        r_rr_ptr     <= w_win;
      end else if (w_issue) begin
        r_stage_vld <= 1'b0;
      end

      if (clear_i || w_issue) begin
        r_stall_cnt <= '0;
      end else if (r_stage_vld && sw_we_i && (r_stall_cnt != SCW'(MaxStall))) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign gnt_o           = w_gnt;
  assign de_o            = w_issue;
  assign d_o             = r_stage_data;
  assign busy_o          = r_stage_vld;
  assign starve_o        = (r_stall_cnt == SCW'(MaxStall)) & r_stage_vld;
  assign dbg_rr_ptr_o    = r_rr_ptr;
  assign dbg_stall_cnt_o = r_stall_cnt;

endmodule
